// File: rtl/conv_ctrl_pkg.sv
// Shared types and defaults for the conv job controller blocks.
package conv_ctrl_pkg;

    localparam int unsigned DEF_CNT_WIDTH      = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_DATA,
        LOAD,
        WAIT_FULL,
        COMPUTE,
        WAIT_DONE,
        RELEASE,
        FIN,
        CLEANUP
    } sched_state_t;

endpackage

// File: rtl/cycle_watchdog.sv
// Counts cycles while EN is high; EXPIRED flags the last allowed cycle. TIMEOUT_CYCLES=0 disables it.
module cycle_watchdog
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    input  logic EN,
    output logic EXPIRED
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{CLK, RESET, CLR, EN};
            assign EXPIRED       = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Saturate at the terminal count so EXPIRED stays up until the owner reacts.
            always_comb begin
                cnt_d = cnt_q;
                if (CLR) begin
                    cnt_d = '0;
                end else if (EN && !EXPIRED) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign EXPIRED = EN && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/weight_load_sched.sv
// Sequences weight_in_ctrl and the MAC array through NUM_SETS load/compute/release rounds,
// with abort and watchdog recovery through a single cleanup pulse.
module weight_load_sched
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [CNT_WIDTH-1:0] NUM_SETS,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 TIMEOUT,
    output logic [CNT_WIDTH-1:0] SET_IDX,
    input  logic                 FIFO_EMPTY,
    input  logic                 WS_FULL,
    output logic                 CLEAR_FIFO,
    output logic                 LOAD_WS,
    output logic                 WS_RELEASE,
    output logic                 COMPUTE_START,
    input  logic                 COMPUTE_DONE
);

    sched_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic                 timeout_q, timeout_d;
    logic                 ws_full_q;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load_ws_q, load_ws_d;
    logic                 clear_fifo_q, clear_fifo_d;
    logic                 ws_release_q, ws_release_d;
    logic                 compute_start_q, compute_start_d;
    logic                 wd_en;
    logic                 wd_expired;

    assign wd_en = (state_q == WAIT_FULL) || (state_q == WAIT_DONE);

    cycle_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK    (CLK),
        .RESET  (RESET),
        .CLR    (!wd_en),
        .EN     (wd_en),
        .EXPIRED(wd_expired)
    );

    // Next state and Moore output decode; outputs follow the state being entered.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        idx_d     = idx_q;
        timeout_d = timeout_q;

        if ((state_q != IDLE) && ABORT) begin
            state_d = CLEANUP;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        num_d     = NUM_SETS;
                        idx_d     = '0;
                        timeout_d = 1'b0;
                        state_d   = (NUM_SETS != '0) ? WAIT_DATA : FIN;
                    end
                end
                WAIT_DATA: if (!FIFO_EMPTY) state_d = LOAD;
                LOAD:      state_d = WAIT_FULL;
                WAIT_FULL: begin
                    if (ws_full_q) begin
                        state_d = COMPUTE;
                    end else if (wd_expired) begin
                        state_d   = CLEANUP;
                        timeout_d = 1'b1;
                    end
                end
                COMPUTE:   state_d = WAIT_DONE;
                WAIT_DONE: begin
                    if (COMPUTE_DONE) begin
                        state_d = RELEASE;
                    end else if (wd_expired) begin
                        state_d   = CLEANUP;
                        timeout_d = 1'b1;
                    end
                end
                RELEASE: begin
                    if (idx_q == (num_q - CNT_WIDTH'(1))) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + CNT_WIDTH'(1);
                        state_d = WAIT_DATA;
                    end
                end
                FIN:     state_d = IDLE;
                CLEANUP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d          = (state_d != IDLE);
        load_ws_d       = (state_d == LOAD);
        compute_start_d = (state_d == COMPUTE);
        ws_release_d    = (state_d == RELEASE) || (state_d == CLEANUP);
        clear_fifo_d    = (state_d == CLEANUP);
        // DONE trails FIN by one cycle so it lands as BUSY drops.
        done_d          = (state_q == FIN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            num_q           <= '0;
            idx_q           <= '0;
            timeout_q       <= 1'b0;
            ws_full_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            load_ws_q       <= 1'b0;
            clear_fifo_q    <= 1'b0;
            ws_release_q    <= 1'b0;
            compute_start_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            num_q           <= num_d;
            idx_q           <= idx_d;
            timeout_q       <= timeout_d;
            ws_full_q       <= WS_FULL;
            busy_q          <= busy_d;
            done_q          <= done_d;
            load_ws_q       <= load_ws_d;
            clear_fifo_q    <= clear_fifo_d;
            ws_release_q    <= ws_release_d;
            compute_start_q <= compute_start_d;
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign TIMEOUT       = timeout_q;
    assign SET_IDX       = idx_q;
    assign CLEAR_FIFO    = clear_fifo_q;
    assign LOAD_WS       = load_ws_q;
    assign WS_RELEASE    = ws_release_q;
    assign COMPUTE_START = compute_start_q;

endmodule

// File: tb/tb_weight_load_sched.sv
// Directed bench for weight_load_sched with a 16-cycle watchdog.
module tb_weight_load_sched;

    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] num_sets;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] set_idx;
    logic          fifo_empty;
    logic          ws_full;
    logic          clear_fifo;
    logic          load_ws;
    logic          ws_release;
    logic          compute_start;
    logic          compute_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_load, n_comp, n_rel, n_done;

    weight_load_sched #(
        .CNT_WIDTH     (CW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .START        (start),
        .ABORT        (abort),
        .NUM_SETS     (num_sets),
        .BUSY         (busy),
        .DONE         (done),
        .TIMEOUT      (timeout),
        .SET_IDX      (set_idx),
        .FIFO_EMPTY   (fifo_empty),
        .WS_FULL      (ws_full),
        .CLEAR_FIFO   (clear_fifo),
        .LOAD_WS      (load_ws),
        .WS_RELEASE   (ws_release),
        .COMPUTE_START(compute_start),
        .COMPUTE_DONE (compute_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, " busy"},   32'(busy), 32'd0);
        chk({tag, " done"},   32'(done), 32'd0);
        chk({tag, " clr"},    32'(clear_fifo), 32'd0);
        chk({tag, " load"},   32'(load_ws), 32'd0);
        chk({tag, " rel"},    32'(ws_release), 32'd0);
        chk({tag, " cstart"}, 32'(compute_start), 32'd0);
    endtask

    // Sets of 19 cycles: LOAD at r=0, WS_FULL driven r=4..16, COMPUTE at r=6,
    // COMPUTE_DONE at r=16, RELEASE at r=17; START was in cycle 0.
    task automatic sched(input int lo, input int hi, input int n);
        for (int c = lo; c <= hi; c++) begin
            int s, r, ei;
            bit v;
            s  = (c >= 2) ? (c - 2) / 19 : 0;
            r  = (c >= 2) ? (c - 2) % 19 : 0;
            v  = (c >= 2) && (s < n);
            ei = ((c - 1) / 19 < n - 1) ? (c - 1) / 19 : n - 1;
            chk($sformatf("load c%0d", c),   32'(load_ws),       32'(v && r == 0));
            chk($sformatf("cstart c%0d", c), 32'(compute_start), 32'(v && r == 6));
            chk($sformatf("rel c%0d", c),    32'(ws_release),    32'(v && r == 17));
            chk($sformatf("clr c%0d", c),    32'(clear_fifo),    32'd0);
            chk($sformatf("done c%0d", c),   32'(done),          32'(c == 19 * n + 2));
            chk($sformatf("busy c%0d", c),   32'(busy),          32'(c >= 1 && c <= 19 * n + 1));
            chk($sformatf("idx c%0d", c),    32'(set_idx),       32'(ei));
            n_load += int'(load_ws);
            n_comp += int'(compute_start);
            n_rel  += int'(ws_release);
            n_done += int'(done);
            ws_full      = v && r >= 4 && r <= 16;
            compute_done = v && r == 16;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: bench did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_sets = '0;
        fifo_empty = 1'b1; ws_full = 1'b0; compute_done = 1'b0;
        step();
        step();
        chk_all_low("reset");
        chk("reset timeout", 32'(timeout), 32'd0);
        chk("reset idx",     32'(set_idx), 32'd0);
        rst = 1'b0;
        step();

        // 1: three full sets
        n_load = 0; n_comp = 0; n_rel = 0; n_done = 0;
        fifo_empty = 1'b0; num_sets = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        sched(1, 60, 3);
        chk("t1 loads",    32'(n_load), 32'd3);
        chk("t1 computes", 32'(n_comp), 32'd3);
        chk("t1 releases", 32'(n_rel),  32'd3);
        chk("t1 dones",    32'(n_done), 32'd1);
        chk("t1 idx hold", 32'(set_idx), 32'd2);
        chk("t1 busy end", 32'(busy), 32'd0);

        // 2: zero sets
        num_sets = '0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t2 c1 busy", 32'(busy), 32'd1);
        chk("t2 c1 done", 32'(done), 32'd0);
        chk("t2 c1 load", 32'(load_ws), 32'd0);
        step();
        chk("t2 c2 done",   32'(done), 32'd1);
        chk("t2 c2 busy",   32'(busy), 32'd0);
        chk("t2 c2 load",   32'(load_ws), 32'd0);
        chk("t2 c2 cstart", 32'(compute_start), 32'd0);
        chk("t2 c2 idx",    32'(set_idx), 32'd0);
        step();
        chk("t2 c3 done", 32'(done), 32'd0);

        // 3: long wait for data, then WS_FULL seen on the last watchdog cycle
        fifo_empty = 1'b1; num_sets = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            chk($sformatf("t3 busy c%0d", i),    32'(busy), 32'd1);
            chk($sformatf("t3 load c%0d", i),    32'(load_ws), 32'd0);
            chk($sformatf("t3 timeout c%0d", i), 32'(timeout), 32'd0);
            step();
        end
        fifo_empty = 1'b0;
        step();
        chk("t3 load after data", 32'(load_ws), 32'd1);
        step();
        for (int t = 1; t <= 14; t++) begin
            chk($sformatf("t3 cstart t%0d", t), 32'(compute_start), 32'd0);
            chk($sformatf("t3 clr t%0d", t),    32'(clear_fifo), 32'd0);
            step();
        end
        ws_full = 1'b1;
        step();
        chk("t3 t16 cstart", 32'(compute_start), 32'd0);
        chk("t3 t16 clr",    32'(clear_fifo), 32'd0);
        chk("t3 t16 busy",   32'(busy), 32'd1);
        step();
        chk("t3 t17 cstart",  32'(compute_start), 32'd1);
        chk("t3 t17 timeout", 32'(timeout), 32'd0);
        chk("t3 t17 clr",     32'(clear_fifo), 32'd0);
        step();
        compute_done = 1'b1;
        step();
        chk("t3 t19 rel", 32'(ws_release), 32'd1);
        chk("t3 t19 clr", 32'(clear_fifo), 32'd0);
        compute_done = 1'b0; ws_full = 1'b0;
        step();
        chk("t3 t20 done", 32'(done), 32'd0);
        chk("t3 t20 busy", 32'(busy), 32'd1);
        step();
        chk("t3 t21 done",    32'(done), 32'd1);
        chk("t3 t21 busy",    32'(busy), 32'd0);
        chk("t3 t21 timeout", 32'(timeout), 32'd0);

        // 4: watchdog expiry in WAIT_FULL
        num_sets = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t4 c2 load", 32'(load_ws), 32'd1);
        step();
        for (int c = 3; c <= 18; c++) begin
            chk($sformatf("t4 clr c%0d", c),     32'(clear_fifo), 32'd0);
            chk($sformatf("t4 timeout c%0d", c), 32'(timeout), 32'd0);
            step();
        end
        chk("t4 c19 clr",     32'(clear_fifo), 32'd1);
        chk("t4 c19 rel",     32'(ws_release), 32'd1);
        chk("t4 c19 timeout", 32'(timeout), 32'd1);
        chk("t4 c19 done",    32'(done), 32'd0);
        chk("t4 c19 busy",    32'(busy), 32'd1);
        step();
        chk_all_low("t4 c20");
        chk("t4 c20 timeout", 32'(timeout), 32'd1);
        repeat (5) step();
        chk("t4 sticky", 32'(timeout), 32'd1);
        num_sets = '0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4 restart timeout", 32'(timeout), 32'd0);
        chk("t4 restart busy",    32'(busy), 32'd1);
        step();
        chk("t4 restart done", 32'(done), 32'd1);
        step();

        // 5: ABORT in WAIT_DONE of set 1 of 4; START mid-job ignored
        num_sets = 16'd4; start = 1'b1;
        step();
        start = 1'b0;
        sched(1, 9, 4);
        start = 1'b1; num_sets = 16'd7;
        sched(10, 10, 4);
        start = 1'b0; num_sets = 16'd4;
        sched(11, 29, 4);
        chk("t5 c30 busy", 32'(busy), 32'd1);
        chk("t5 c30 rel",  32'(ws_release), 32'd0);
        abort = 1'b1;
        step();
        chk("t5 c31 clr",  32'(clear_fifo), 32'd1);
        chk("t5 c31 rel",  32'(ws_release), 32'd1);
        chk("t5 c31 done", 32'(done), 32'd0);
        chk("t5 c31 busy", 32'(busy), 32'd1);
        chk("t5 c31 idx",  32'(set_idx), 32'd1);
        abort = 1'b0; ws_full = 1'b0;
        step();
        chk_all_low("t5 c32");
        chk("t5 c32 timeout", 32'(timeout), 32'd0);
        step();
        chk("t5 c33 done", 32'(done), 32'd0);

        // 6: RESET in WAIT_FULL of set 1
        num_sets = 16'd2; start = 1'b1;
        step();
        start = 1'b0;
        sched(1, 22, 2);
        rst = 1'b1;
        step();
        chk_all_low("t6 c24");
        chk("t6 c24 idx",     32'(set_idx), 32'd0);
        chk("t6 c24 timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        step();
        chk_all_low("t6 c25");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
